// File: rtl/video_pkg.sv
// video_pkg: shared pattern modes and colour tables for the video pattern generators
package video_pkg;

  typedef enum logic [2:0] {
    BARS    = 3'd0,
    CHECKER = 3'd1,
    RAMP    = 3'd2,
    SOLID   = 3'd3,
    MOVING  = 3'd4
  } pattern_mode_t;

  // Colours are {R,G,B} on/off masks, expanded to full channel width by the user.
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE  = 3'b001;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_COLOURS [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

endpackage

// File: rtl/video_pos_counter.sv
// video_pos_counter: pixel/line/frame position tracker driven by timing-generator pulses
module video_pos_counter
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  localparam int XW = $clog2(H_ACTIVE),
  localparam int YW = $clog2(V_ACTIVE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          visible,
  input  logic          end_of_line,
  input  logic          end_of_frame,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);

  logic          line_vis;
  logic [XW:0]   frame_cnt;

  // x counts visible pixels, y counts lines that showed at least one pixel; both saturate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      line_vis  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      x         <= end_of_line ? '0 : (visible && x != XW'(H_ACTIVE - 1)) ? x + 1'b1 : x;
      line_vis  <= end_of_line ? 1'b0 : line_vis | visible;
      y         <= end_of_frame ? '0
                 : (end_of_line && (line_vis || visible) && y != YW'(V_ACTIVE - 1)) ? y + 1'b1 : y;
      frame_cnt <= end_of_frame ? frame_cnt + 1'b1 : frame_cnt;
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: runtime-selectable test pattern source with frame-boundary mode switching
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BPC        = 8,
  parameter int BAR_WIDTH  = 80,
  parameter int CHECK_LOG2 = 5,
  parameter int MOVE_STEP  = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               visible_i,
  input  logic               end_of_line_i,
  input  logic               end_of_frame_i,
  input  logic [2:0]         mode_i,
  input  logic [3*BPC-1:0]   solid_rgb_i,
  output logic [3*BPC-1:0]   rgb_o,
  output logic               visible_o
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int SW = $clog2(BAR_WIDTH);

  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [XW-1:0]    pos;
  logic [XW:0]      pos_step;
  logic [XW:0]      pos_end;
  logic             in_bar;
  logic [2:0]       active_mode;
  logic [2:0]       bar_idx;
  logic [SW-1:0]    bar_sub;
  logic             bar_last;
  logic [3*BPC-1:0] solid_reg;
  logic [3*BPC-1:0] pixel;

  function automatic logic [3*BPC-1:0] expand(input logic [2:0] c);
    return {{BPC{c[2]}}, {BPC{c[1]}}, {BPC{c[0]}}};
  endfunction

  video_pos_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pos (
    .clk          (clk_i),
    .rst_n        (rst_n_i),
    .visible      (visible_i),
    .end_of_line  (end_of_line_i),
    .end_of_frame (end_of_frame_i),
    .x            (x),
    .y            (y)
  );

  assign bar_last = bar_sub == SW'(BAR_WIDTH - 1);
  assign pos_step = {1'b0, pos} + (XW + 1)'(MOVE_STEP);
  assign pos_end  = {1'b0, pos} + (XW + 1)'(BAR_WIDTH);
  assign in_bar   = (x >= pos) && ({1'b0, x} < pos_end);

  // Bar tracking without a divider, moving-bar origin, and mode/colour latched at frame end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      bar_idx     <= '0;
      bar_sub     <= '0;
      pos         <= '0;
      active_mode <= BARS;
      solid_reg   <= '0;
    end else begin
      if (end_of_line_i) begin
        bar_idx <= '0;
        bar_sub <= '0;
      end else if (visible_i) begin
        bar_sub <= bar_last ? '0 : bar_sub + 1'b1;
        bar_idx <= (bar_last && bar_idx != 3'd7) ? bar_idx + 1'b1 : bar_idx;
      end
      if (end_of_frame_i) begin
        active_mode <= mode_i;
        solid_reg   <= solid_rgb_i;
        pos         <= (pos_step >= (XW + 1)'(H_ACTIVE)) ? XW'(pos_step - (XW + 1)'(H_ACTIVE))
                                                         : pos_step[XW-1:0];
      end
    end
  end

  // Pattern mux for the pixel at the current position
  always_comb begin
    pixel = '0;
    case (active_mode)
      BARS:    pixel = expand(BAR_COLOURS[bar_idx]);
      CHECKER: pixel = expand((x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? BLACK : WHITE);
      RAMP:    pixel = {3{x[BPC-1:0]}};
      SOLID:   pixel = solid_reg;
      MOVING:  pixel = expand(in_bar ? WHITE : BLUE);
      default: pixel = '0;
    endcase
  end

  // Output register; blanked cycles are forced to black
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rgb_o     <= '0;
      visible_o <= 1'b0;
    end else begin
      rgb_o     <= visible_i ? pixel : '0;
      visible_o <= visible_i;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: randomized frames checked cycle-by-cycle against a position/pattern model
module tb_video_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        visible_i = 1'b0;
  logic        end_of_line_i = 1'b0;
  logic        end_of_frame_i = 1'b0;
  logic [2:0]  mode_i = '0;
  logic [23:0] solid_rgb_i = '0;
  logic [23:0] rgb_o;
  logic        visible_o;

  int checks = 0;
  int failures = 0;

  int          m_px;
  int          m_y;
  int          m_frame;
  int          m_mode;
  logic [23:0] m_solid;
  bit          m_lv;

  video_pattern_gen dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n_i),
    .visible_i      (visible_i),
    .end_of_line_i  (end_of_line_i),
    .end_of_frame_i (end_of_frame_i),
    .mode_i         (mode_i),
    .solid_rgb_i    (solid_rgb_i),
    .rgb_o          (rgb_o),
    .visible_o      (visible_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (frame %0d y %0d px %0d mode %0d)",
               tag, got, exp, m_frame, m_y, m_px, m_mode);
    end
  endtask

  function automatic logic [23:0] ref_pix(input int px, input int y, input int frame,
                                          input int mode, input logic [23:0] solid);
    logic [23:0] bars [8];
    logic [7:0]  g;
    int          x;
    int          pos;
    int          b;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    x   = (px > 639) ? 639 : px;
    pos = (frame * 4) % 640;
    b   = (px / 80 > 7) ? 7 : px / 80;
    g   = 8'(x % 256);
    case (mode)
      0:       return bars[b];
      1:       return (((x / 32) % 2) == ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      2:       return {g, g, g};
      3:       return solid;
      4:       return (x >= pos && x < pos + 80) ? 24'hFFFFFF : 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_reset();
    m_px = 0; m_y = 0; m_frame = 0; m_mode = 0; m_solid = '0; m_lv = 0;
  endtask

  task automatic step(input bit r, input bit v, input bit eol, input bit eof,
                      input logic [2:0] m, input logic [23:0] s);
    logic [23:0] exp_rgb;
    bit          lv;
    rst_n_i = r; visible_i = v; end_of_line_i = eol; end_of_frame_i = eof;
    mode_i = m; solid_rgb_i = s;
    exp_rgb = (r && v) ? ref_pix(m_px, m_y, m_frame, m_mode, m_solid) : 24'h0;
    @(posedge clk);
    #1;
    check("rgb", {8'h0, rgb_o}, {8'h0, exp_rgb});
    check("visible", {31'h0, visible_o}, {31'h0, r && v});
    if (!r) model_reset();
    else begin
      lv = m_lv || v;
      if (v) m_px++;
      if (eol) begin
        m_px = 0;
        if (lv && m_y < 479) m_y++;
        m_lv = 0;
      end else m_lv = lv;
      if (eof) begin
        m_y = 0; m_frame++; m_mode = int'(m); m_solid = s;
      end
    end
  endtask

  // mode_i/solid_rgb_i are scrambled every cycle except on the frame-ending pulse
  task automatic run_line(input int nvis, input bit eof, input logic [2:0] m, input logic [23:0] s);
    int left = nvis;
    int tail = $urandom_range(0, 2);
    bit v;
    bit last;
    if (nvis == 0 && tail == 0) tail = 1;
    while (left > 0 || tail > 0) begin
      if (left > 0) begin
        v = ($urandom_range(0, 7) != 0);
        if (v) left--;
      end else begin
        v = 0;
        tail--;
      end
      last = (left == 0 && tail == 0);
      step(1, v, last, last && eof,
           (last && eof) ? m : 3'($urandom_range(0, 7)),
           (last && eof) ? s : 24'($urandom));
    end
  endtask

  task automatic run_frame(input int lines, input int nvis, input logic [2:0] m, input logic [23:0] s);
    for (int i = 0; i < lines; i++) run_line(nvis, i == lines - 1, m, s);
  endtask

  initial begin
    model_reset();
    repeat (3) step(0, 1, 0, 0, 3'd3, 24'hABCDEF);
    run_frame(2, 700, 3'd1, 24'h0);
    run_frame(40, 40, 3'd2, 24'h0);
    run_frame(2, 300, 3'd3, 24'h123456);
    run_frame(3, 50, 3'd4, 24'h0);
    for (int f = 0; f < 170; f++) run_frame(1, 130, 3'd4, 24'h0);
    run_frame(1, 20, 3'd5, 24'h0);
    run_frame(1, 20, 3'd6, 24'h0);
    run_frame(1, 20, 3'd7, 24'h0);
    run_frame(1, 20, 3'd2, 24'h0);
    run_line(100, 0, 3'd0, 24'h0);
    step(0, 1, 1, 1, 3'd2, 24'h55AA55);
    run_frame(1, 700, 3'd1, 24'h0);
    for (int f = 0; f < 12; f++) begin
      int lines = $urandom_range(1, 3);
      logic [2:0] nm = 3'($urandom_range(0, 7));
      logic [23:0] ns = 24'($urandom);
      for (int i = 0; i < lines; i++)
        run_line(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 700), i == lines - 1, nm, ns);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
